// File: rtl/uart_pkg.sv
// Shared constants and types for the UART transmit path (ext_uart_write side).
package uart_pkg;

    localparam int unsigned UART_DATA_BITS            = 8;
    localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 217;

    typedef struct packed {
        logic                      valid;
        logic [UART_DATA_BITS-1:0] data;
    } uart_opt_byte_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_emitter_if.sv
// Core-to-UART write handshake: {valid, byte} towards the emitter, ready back to the core.
interface uart_emitter_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS:0] wr_opt_byte;
    logic                    wr_ready;

    modport master (output wr_opt_byte, input wr_ready);
    modport slave  (input wr_opt_byte, output wr_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering bytes between the core handshake and the serializer.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam logic [AW:0]   PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal low bits with differing MSB means full.
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty   = (wptr == rptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_emitter.sv
// UART transmitter (8N1) behind the core's ext_uart_write port, LSB first, line idle high.
// Define UART_EMITTER_PARITY_EN to append an even-parity bit after the data bits.
module uart_emitter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    uart_emitter_if.slave wr,
    output logic          line_out,
    output logic          busy
);
    localparam int unsigned   BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    uart_opt_byte_t            req;
    uart_tx_state_t            state;
    uart_tx_state_t            state_nxt;
    logic                      push;
    logic                      pop;
    logic                      full;
    logic                      empty;
    logic [UART_DATA_BITS-1:0] fifo_dout;
    logic [UART_DATA_BITS-1:0] shreg;
    logic [UART_DATA_BITS-1:0] shreg_nxt;
    logic [BW-1:0]             baud_cnt;
    logic [2:0]                bit_idx;
    logic                      tick;
    logic                      line_nxt;
`ifdef UART_EMITTER_PARITY_EN
    logic                      par_bit;
`endif

    assign req         = uart_opt_byte_t'(wr.wr_opt_byte);
    assign wr.wr_ready = !full;
    assign push        = req.valid && !full;
    assign tick        = (baud_cnt == BAUD_LAST);
    assign busy        = (state != IDLE) || !empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .CLK   (CLK),
        .RST_N (RST_N),
        .push  (push),
        .pop   (pop),
        .din   (req.data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tick && (bit_idx == BIT_LAST)) begin
`ifdef UART_EMITTER_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    state_nxt = empty ? IDLE : START;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // line_out is registered, so its next value is derived from next state and next shift data.
    always_comb begin
        pop = 1'b0;
        if (!empty) begin
            pop = (state == IDLE) || ((state == STOP) && tick);
        end

        shreg_nxt = shreg;
        if (pop) begin
            shreg_nxt = fifo_dout;
        end else if ((state == DATA) && tick) begin
            shreg_nxt = shreg >> 1;
        end

        line_nxt = 1'b1;
        case (state_nxt)
            START:   line_nxt = 1'b0;
            DATA:    line_nxt = shreg_nxt[0];
`ifdef UART_EMITTER_PARITY_EN
            PARITY:  line_nxt = par_bit;
`endif
            default: line_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            line_out <= 1'b1;
            shreg    <= '0;
            baud_cnt <= '0;
            bit_idx  <= '0;
`ifdef UART_EMITTER_PARITY_EN
            par_bit  <= 1'b0;
`endif
        end else begin
            line_out <= line_nxt;
            shreg    <= shreg_nxt;

            if ((state == IDLE) || tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_ONE;
            end

            if (state != DATA) begin
                bit_idx <= '0;
            end else if (tick) begin
                bit_idx <= bit_idx + 3'd1;
            end

`ifdef UART_EMITTER_PARITY_EN
            if (pop) begin
                par_bit <= ^fifo_dout;
            end
`endif
        end
    end

endmodule

// File: tb/tb_uart_emitter.sv
// Randomized bench for uart_emitter against a frame-timing reference model.
module tb_uart_emitter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_EMITTER_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FL = NBITS * CPB;

    typedef struct {
        int         acc;
        int         start;
        logic [7:0] data;
    } frame_t;

    logic CLK = 1'b0;
    logic RST_N;
    logic line_out;
    logic busy;

    uart_emitter_if wr_if ();

    uart_emitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .wr       (wr_if),
        .line_out (line_out),
        .busy     (busy)
    );

    always #5 CLK = ~CLK;

    frame_t     frames[$];
    logic       samples[$];
    logic       capture;
    int         t;
    int         n_checks;
    int         n_errors;
    logic [7:0] t2_bytes [5] = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, t, got, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_EMITTER_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_line(input int c);
        foreach (frames[k]) begin
            if (c >= frames[k].start && c < frames[k].start + FL)
                return frame_bit(frames[k].data, (c - frames[k].start) / CPB);
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int c);
        foreach (frames[k]) begin
            if (frames[k].acc < c && c < frames[k].start + FL) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_ready(input int c);
        int held = 0;
        foreach (frames[k]) begin
            if (frames[k].acc < c && c < frames[k].start) held++;
        end
        return held < DEPTH;
    endfunction

    // A byte accepted at cycle a starts two cycles later, or right after the previous frame.
    task automatic add_frame(input int a, input logic [7:0] d);
        int last_end = 0;
        int s;
        if (frames.size() > 0) last_end = frames[frames.size()-1].start + FL;
        s = (a + 2 > last_end) ? a + 2 : last_end;
        frames.push_back('{a, s, d});
    endtask

    task automatic step(input logic v, input logic [7:0] d, output logic acc);
        @(negedge CLK);
        t++;
        check("line_out", 32'(line_out), 32'(exp_line(t)));
        check("busy", 32'(busy), 32'(exp_busy(t)));
        check("wr_ready", 32'(wr_if.wr_ready), 32'(exp_ready(t)));
        if (capture) samples.push_back(line_out);
        wr_if.wr_opt_byte = {v, d};
        acc = v && exp_ready(t);
        if (acc) add_frame(t, d);
    endtask

    task automatic step_idle();
        logic dummy;
        step(1'b0, 8'h00, dummy);
    endtask

    task automatic drain();
        int end_t = t + 2;
        if (frames.size() > 0) end_t = frames[frames.size()-1].start + FL + 2;
        while (t < end_t) step_idle();
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        t++;
        RST_N = 1'b0;
        wr_if.wr_opt_byte = '0;
        #1;
        frames.delete();
        check("rst_async_line", 32'(line_out), 32'd1);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_ready", 32'(wr_if.wr_ready), 32'd1);
        repeat (3) step_idle();
        RST_N = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        logic acc;
        int   n;
        int   val;
        int   guard;
        int   i;
        int   nb;
        logic [7:0] b;

        RST_N = 1'b0;
        wr_if.wr_opt_byte = '0;
        capture = 1'b0;
        t = 0;
        n_checks = 0;
        n_errors = 0;

        repeat (3) @(negedge CLK);
        check("reset_line", 32'(line_out), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(wr_if.wr_ready), 32'd1);
        RST_N = 1'b1;

        // Valid low with a byte on the bus: nothing may happen.
        repeat (100) step(1'b0, 8'hFF, acc);
        check("novalid_line", 32'(line_out), 32'd1);
        check("novalid_busy", 32'(busy), 32'd0);

        // Single 0x55 frame: exact start latency and busy release.
        step(1'b1, 8'h55, acc);
        n = t;
        step_idle();
        check("t1_line_before_start", 32'(line_out), 32'd1);
        step_idle();
        check("t1_start_bit", 32'(line_out), 32'd0);
        while (t < n + 2 + FL) step_idle();
        check("t1_busy_released", 32'(busy), 32'd0);
        drain();

        // Five back-to-back pushes into a depth-4 FIFO.
        n = t + 1;
        for (int k = 0; k < 5; k++) step(1'b1, t2_bytes[k], acc);
        step_idle();
        check("t2_ready_low", 32'(wr_if.wr_ready), 32'd0);
        while (t < n + 1 + FL) step_idle();
        check("t2_ready_before_pop", 32'(wr_if.wr_ready), 32'd0);
        step_idle();
        check("t2_ready_after_pop", 32'(wr_if.wr_ready), 32'd1);
        drain();

        // Reset in the middle of data bit 3 of 0x0F, then a clean 0x12 frame.
        step(1'b1, 8'h0F, acc);
        n = t;
        while (t < n + 2 + 4 * CPB + 1) step_idle();
        check("t4_bit3_before_reset", 32'(line_out), 32'd1);
        apply_reset();
        step(1'b1, 8'h12, acc);
        drain();

`ifdef UART_EMITTER_PARITY_EN
        step(1'b1, 8'h07, acc);
        n = t;
        while (t < n + 2 + 9 * CPB + 1) step_idle();
        check("t5_parity_07", 32'(line_out), 32'd1);
        drain();
        step(1'b1, 8'h03, acc);
        n = t;
        while (t < n + 2 + 9 * CPB + 1) step_idle();
        check("t5_parity_03", 32'(line_out), 32'd0);
        drain();
`endif

        // Stream 0x00..0x0F with valid held high, then decode the captured line.
        samples.delete();
        capture = 1'b1;
        val = 0;
        guard = 0;
        while (val < 16 && guard < 3000) begin
            step(1'b1, 8'(val), acc);
            if (acc) val++;
            guard++;
        end
        drain();
        capture = 1'b0;
        i = 0;
        nb = 0;
        while (i < samples.size()) begin
            if (samples[i] == 1'b0 && i + FL <= samples.size()) begin
                for (int k = 0; k < 8; k++) b[k] = samples[i + (k + 1) * CPB + CPB / 2];
                check("t6_decoded_byte", 32'(b), 32'(nb));
                check("t6_stop_bit", 32'(samples[i + (NBITS - 1) * CPB + CPB / 2]), 32'd1);
                nb++;
                i += FL;
            end else begin
                i++;
            end
        end
        check("t6_decoded_count", 32'(nb), 32'd16);

        // Random traffic with random gaps.
        repeat (400) step(($urandom_range(0, 2) == 0), 8'($urandom), acc);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
